sprite_ram_loader: RTL and testbench

SPRITE_RAM_LOADER -- requirements
Module: sprite_ram_loader

---
 rtl/sprite_ram_loader.sv | 206 ++++++++++++++++++++
 tb/tb_sprite_ram_loader.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_ram_loader.sv
// -----------------------------------------------------------------------------
// sprite_ram_loader
//
// Streams a row-major sprite image from a valid/ready pixel source into a
// sprite RAM. Every accepted pixel is written one cycle later at
// (base + pixel index), wrapping modulo 2^ADDR_W. A load ends after
// IMAGE_WIDTH*IMAGE_HEIGHT pixels, signalled by a one-cycle load_done pulse
// that coincides with the final RAM write. An abort cancels the load without
// signalling completion.
//
// Ports:
//   Clk            - single clock, rising edge
//   Reset_n        - asynchronous active-low reset
//   start          - begin a load (only honoured while idle)
//   abort          - cancel the load in progress
//   base_addr      - RAM offset of pixel (0,0), captured on accepted start
//   pix_valid      - source presents a pixel on pix_data
//   pix_data       - pixel {R,G,B}, row-major, row 0 first
//   pix_ready      - loader accepts pix_data this cycle
//   ram_we         - sprite RAM write strobe
//   ram_addr       - sprite RAM write address
//   ram_data       - sprite RAM write data
//   busy           - a load is in progress
//   load_done      - one-cycle pulse on successful completion
//
// Optional feature (macro SPRITE_LOADER_CKSUM_EN):
//   expected_cksum - reference sum of all pixels of the image
//   cksum_ok       - set when the completed image sums to expected_cksum,
//                    held until the next accepted start
// -----------------------------------------------------------------------------
module sprite_ram_loader #(
    parameter int IMAGE_WIDTH  = 50,
    parameter int IMAGE_HEIGHT = 50,
    parameter int ADDR_W       = 19,
    parameter int PIX_W        = 24
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              pix_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [PIX_W-1:0]  ram_data,
    output logic              busy,
    output logic              load_done
`ifdef SPRITE_LOADER_CKSUM_EN
    ,
    input  logic [PIX_W-1:0]  expected_cksum,
    output logic              cksum_ok
`endif
);

    localparam int X_W = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
    localparam int Y_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam logic [X_W-1:0] X_LAST = X_W'(IMAGE_WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMAGE_HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] pos_q, pos_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [PIX_W-1:0]  ram_data_q, ram_data_d;

`ifdef SPRITE_LOADER_CKSUM_EN
    logic [PIX_W-1:0]  sum_q, sum_d;
    logic              cksum_ok_q, cksum_ok_d;
`endif

    logic handshake;
    logic last_pixel;

    // Readiness depends on the state register only, so the source never sees
    // a combinational path from its own pix_valid back to pix_ready.
    assign pix_ready  = (state_q == LOAD);
    assign handshake  = pix_valid & pix_ready;
    assign last_pixel = (x_q == X_LAST) && (y_q == Y_LAST);

    assign busy      = (state_q == LOAD);
    assign load_done = (state_q == DONE);
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_data  = ram_data_q;

`ifdef SPRITE_LOADER_CKSUM_EN
    assign cksum_ok = cksum_ok_q;
`endif

    // Next-state logic. The RAM write is issued from registers in the cycle
    // after the handshake; x/y track the raster position so the end of the
    // image is detected without a wide multiply-compare on pos.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        pos_d      = pos_q;
        x_d        = x_q;
        y_d        = y_q;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
`ifdef SPRITE_LOADER_CKSUM_EN
        sum_d      = sum_q;
        cksum_ok_d = cksum_ok_q;
`endif

        case (state_q)
            IDLE: begin
                // start beats a simultaneous abort simply because abort is
                // not looked at in this state.
                if (start) begin
                    state_d = LOAD;
                    base_d  = base_addr;
                    pos_d   = '0;
                    x_d     = '0;
                    y_d     = '0;
`ifdef SPRITE_LOADER_CKSUM_EN
                    sum_d      = '0;
                    cksum_ok_d = 1'b0;
`endif
                end
            end

            LOAD: begin
                if (handshake) begin
                    ram_we_d   = 1'b1;
                    ram_addr_d = base_q + pos_q;
                    ram_data_d = pix_data;
                    pos_d      = pos_q + ADDR_W'(1);
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        y_d = y_q + Y_W'(1);
                    end else begin
                        x_d = x_q + X_W'(1);
                    end
`ifdef SPRITE_LOADER_CKSUM_EN
                    sum_d = sum_q + pix_data;
`endif
                end

                // A same-cycle pixel is still written above, but abort
                // suppresses completion even on the last pixel.
                if (abort) begin
                    state_d = IDLE;
                end else if (handshake && last_pixel) begin
                    state_d = DONE;
`ifdef SPRITE_LOADER_CKSUM_EN
                    cksum_ok_d = (sum_d == expected_cksum);
`endif
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything asynchronously so
    // a load in progress is abandoned immediately.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            base_q     <= '0;
            pos_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
`ifdef SPRITE_LOADER_CKSUM_EN
            sum_q      <= '0;
            cksum_ok_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            pos_q      <= pos_d;
            x_q        <= x_d;
            y_q        <= y_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
`ifdef SPRITE_LOADER_CKSUM_EN
            sum_q      <= sum_d;
            cksum_ok_q <= cksum_ok_d;
`endif
        end
    end

endmodule

// File: tb/tb_sprite_ram_loader.sv
// -----------------------------------------------------------------------------
// tb_sprite_ram_loader
//
// Self-checking bench for sprite_ram_loader. A pixel-count based reference
// model predicts, for every clock, which pixel is accepted, where it lands in
// RAM and when the load completes. Scenario tasks drive randomized traffic
// and compare the DUT outputs against that model cycle by cycle.
// With SPRITE_LOADER_CKSUM_EN defined the checksum ports are exercised too.
// -----------------------------------------------------------------------------
module tb_sprite_ram_loader;

    localparam int W  = 50;
    localparam int H  = 50;
    localparam int AW = 19;
    localparam int PW = 24;
    localparam int N  = W * H;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic          start;
    logic          abort;
    logic [AW-1:0] base_addr;
    logic          pix_valid;
    logic [PW-1:0] pix_data;
    logic          pix_ready;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [PW-1:0] ram_data;
    logic          busy;
    logic          load_done;
`ifdef SPRITE_LOADER_CKSUM_EN
    logic [PW-1:0] expected_cksum;
    logic          cksum_ok;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: a load is just "count accepted pixels until N".
    bit            m_loading;
    bit            m_done;
    int            m_count;
    logic [AW-1:0] m_base;
    bit            m_we;
    logic [AW-1:0] m_addr;
    logic [PW-1:0] m_data;
    logic [PW-1:0] m_sum;
    bit            m_ok;

    // Observations of the most recent scenario run.
    logic [AW-1:0] obs_addr[$];
    logic [PW-1:0] obs_data[$];
    int            done_cnt;
    logic [AW-1:0] done_addr;
    logic          done_we;

    sprite_ram_loader #(
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H),
        .ADDR_W      (AW),
        .PIX_W       (PW)
    ) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .start    (start),
        .abort    (abort),
        .base_addr(base_addr),
        .pix_valid(pix_valid),
        .pix_data (pix_data),
        .pix_ready(pix_ready),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .busy     (busy),
        .load_done(load_done)
`ifdef SPRITE_LOADER_CKSUM_EN
        ,
        .expected_cksum(expected_cksum),
        .cksum_ok      (cksum_ok)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic model_reset();
        m_loading = 1'b0;
        m_done    = 1'b0;
        m_count   = 0;
        m_base    = '0;
        m_we      = 1'b0;
        m_addr    = '0;
        m_data    = '0;
        m_sum     = '0;
        m_ok      = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model across the coming edge,
    // then return #1 after that edge so outputs can be sampled.
    task automatic cycle(input bit v, input logic [PW-1:0] d, input bit s,
                         input bit a, input logic [AW-1:0] b);
        bit was_done;
        pix_valid = v;
        pix_data  = d;
        start     = s;
        abort     = a;
        base_addr = b;
        was_done  = m_done;
        m_done    = 1'b0;
        m_we      = 1'b0;
        if (m_loading) begin
            if (v) begin
                m_we    = 1'b1;
                m_addr  = m_base + AW'(m_count);
                m_data  = d;
                m_count = m_count + 1;
                m_sum   = m_sum + d;
            end
            if (a) begin
                m_loading = 1'b0;
            end else if (v && m_count == N) begin
                m_loading = 1'b0;
                m_done    = 1'b1;
`ifdef SPRITE_LOADER_CKSUM_EN
                m_ok = (m_sum == expected_cksum);
`endif
            end
        end else if (!was_done && s) begin
            m_loading = 1'b1;
            m_base    = b;
            m_count   = 0;
            m_sum     = '0;
            m_ok      = 1'b0;
        end
        @(posedge Clk);
        #1;
    endtask

    // Scenario runner: mode 0 continuous valid / random data, 1 alternating
    // valid with data 1,2,3.., 2 random valid with stray start pulses,
    // 3 continuous valid with every pixel equal to 1. abort_at > 0 aborts on
    // the handshake of that pixel number.
    task automatic run_load(input string name, input logic [AW-1:0] base,
                            input int mode, input int abort_at);
        int            c;
        bit            v, s, a;
        logic [PW-1:0] d;
        logic [AW-1:0] b;
        obs_addr.delete();
        obs_data.delete();
        done_cnt  = 0;
        done_addr = '0;
        done_we   = 1'b0;
        c = 0;
        while ((c == 0 || m_loading || m_done) && c < 4 * N + 10) begin
            if (mode == 1)      v = (c % 2 == 1);
            else if (mode == 2) v = bit'($urandom_range(0, 1));
            else                v = 1'b1;
            if (mode == 1 && v) d = PW'(m_count + 1);
            else if (mode == 3) d = PW'(1);
            else                d = PW'($urandom);
            s = (c == 0);
            a = (c == 0 && mode == 2);
            b = (c == 0) ? base : AW'($urandom);
            if (mode == 2 && c > 0 && $urandom_range(0, 7) == 0) s = 1'b1;
            if (m_done) begin
                s = 1'b1;
                a = 1'b1;
            end
            if (abort_at > 0 && m_loading && v && m_count == abort_at - 1) a = 1'b1;
            cycle(v, d, s, a, b);

            checks++;
            if ({pix_ready, busy, load_done, ram_we} !== {m_loading, m_loading, m_done, m_we}) begin
                errors++;
                $display("[TB] FAIL %s ctrl c=%0d: ready/busy/done/we got %b expected %b",
                         name, c, {pix_ready, busy, load_done, ram_we},
                         {m_loading, m_loading, m_done, m_we});
            end
            checks++;
            if (ram_addr !== m_addr || ram_data !== m_data) begin
                errors++;
                $display("[TB] FAIL %s ram c=%0d: addr/data got %h/%h expected %h/%h",
                         name, c, ram_addr, ram_data, m_addr, m_data);
            end
`ifdef SPRITE_LOADER_CKSUM_EN
            checks++;
            if (cksum_ok !== m_ok) begin
                errors++;
                $display("[TB] FAIL %s cksum_ok c=%0d: got %b expected %b", name, c, cksum_ok, m_ok);
            end
`endif
            if (ram_we === 1'b1) begin
                obs_addr.push_back(ram_addr);
                obs_data.push_back(ram_data);
            end
            if (load_done === 1'b1) begin
                done_cnt++;
                done_addr = ram_addr;
                done_we   = ram_we;
            end
            c++;
        end
        if (c >= 4 * N + 10) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s budget: ran %0d cycles, required fewer", name, c);
        end
    endtask

    task automatic test_reset();
        Reset_n   = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        base_addr = '0;
        pix_valid = 1'b0;
        pix_data  = '0;
`ifdef SPRITE_LOADER_CKSUM_EN
        expected_cksum = '0;
`endif
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        checks++;
        if ({pix_ready, ram_we, busy, load_done, ram_addr, ram_data} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state: got %b/%b/%b/%b %h %h required all zero",
                     pix_ready, ram_we, busy, load_done, ram_addr, ram_data);
        end
        Reset_n = 1'b1;
        // Valid pixels while idle must be neither accepted nor written.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, PW'($urandom), 1'b0, 1'b1, '0);
            checks++;
            if ({pix_ready, busy, load_done, ram_we} !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL idle_no_accept: ready/busy/done/we got %b required 0000",
                         {pix_ready, busy, load_done, ram_we});
            end
        end
    endtask

    task automatic test_full_load();
        int bad;
        run_load("full_load", '0, 0, -1);
        checks++;
        if (obs_addr.size() != N) begin
            errors++;
            $display("[TB] FAIL full_load writes: got %0d required %0d", obs_addr.size(), N);
        end
        bad = 0;
        foreach (obs_addr[i]) if (obs_addr[i] !== AW'(i)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL full_load addr_seq: got %0d misplaced writes required 0", bad);
        end
        checks++;
        if (done_cnt != 1 || done_we !== 1'b1 || done_addr !== AW'(N - 1)) begin
            errors++;
            $display("[TB] FAIL full_load done: got cnt=%0d we=%b addr=%h required 1/1/%h",
                     done_cnt, done_we, done_addr, AW'(N - 1));
        end
    endtask

    task automatic test_gapped();
        int            bad;
        logic [AW-1:0] base;
        base = AW'($urandom);
        run_load("gapped", base, 1, -1);
        checks++;
        if (obs_addr.size() != N) begin
            errors++;
            $display("[TB] FAIL gapped writes: got %0d required %0d", obs_addr.size(), N);
        end
        bad = 0;
        foreach (obs_data[i]) if (obs_data[i] !== PW'(i + 1) || obs_addr[i] !== base + AW'(i)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL gapped order: got %0d out-of-order writes required 0", bad);
        end
    endtask

    task automatic test_wrap_random();
        run_load("wrap_random", 19'h7FFF0, 2, -1);
        checks++;
        if (obs_addr[15] !== 19'h7FFFF || obs_addr[16] !== 19'h00000) begin
            errors++;
            $display("[TB] FAIL wrap addr: pixel15/16 got %h/%h required 7ffff/00000",
                     obs_addr[15], obs_addr[16]);
        end
        checks++;
        if (obs_addr.size() != N || done_cnt != 1) begin
            errors++;
            $display("[TB] FAIL wrap count: writes/done got %0d/%0d required %0d/1",
                     obs_addr.size(), done_cnt, N);
        end
    endtask

    task automatic test_abort();
        logic [AW-1:0] base2;
        run_load("abort", AW'($urandom), 0, 100);
        checks++;
        if (obs_addr.size() != 100 || done_cnt != 0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort: writes/done/busy got %0d/%0d/%b required 100/0/0",
                     obs_addr.size(), done_cnt, busy);
        end
        base2 = AW'($urandom);
        run_load("after_abort", base2, 0, -1);
        checks++;
        if (obs_addr.size() != N || obs_addr[0] !== base2 || done_cnt != 1) begin
            errors++;
            $display("[TB] FAIL after_abort: writes/first/done got %0d/%h/%0d required %0d/%h/1",
                     obs_addr.size(), obs_addr[0], done_cnt, N, base2);
        end
    endtask

    task automatic test_reset_midload();
        int c;
        c = 0;
        cycle(1'b0, '0, 1'b1, 1'b0, AW'($urandom));
        while (m_count < 1000 && c < 2000) begin
            cycle(1'b1, PW'($urandom), 1'b0, 1'b0, '0);
            c++;
        end
        checks++;
        if (ram_we !== 1'b1 || ram_addr !== m_addr || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midload pre_reset: we/addr/busy got %b/%h/%b required 1/%h/1",
                     ram_we, ram_addr, busy, m_addr);
        end
        // Assert reset between clock edges: outputs must clear without a clock.
        #2;
        Reset_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({pix_ready, ram_we, busy, load_done, ram_addr, ram_data} !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset: got %b/%b/%b/%b %h %h required all zero",
                     pix_ready, ram_we, busy, load_done, ram_addr, ram_data);
        end
        for (int i = 0; i < 20; i++) begin
            if (i == 3) Reset_n = 1'b1;
            cycle(1'b1, PW'($urandom), 1'b0, 1'b0, '0);
            checks++;
            if ({pix_ready, busy, load_done, ram_we} !== 4'b0000 || ram_addr !== '0) begin
                errors++;
                $display("[TB] FAIL post_reset c=%0d: ready/busy/done/we got %b addr %h required 0000 0",
                         i, {pix_ready, busy, load_done, ram_we}, ram_addr);
            end
        end
    endtask

`ifdef SPRITE_LOADER_CKSUM_EN
    task automatic test_cksum();
        expected_cksum = 24'd2500;
        run_load("cksum_good", AW'($urandom), 3, -1);
        checks++;
        if (cksum_ok !== 1'b1) begin
            errors++;
            $display("[TB] FAIL cksum_good: got %b required 1", cksum_ok);
        end
        expected_cksum = 24'd2499;
        run_load("cksum_bad", AW'($urandom), 3, -1);
        checks++;
        if (cksum_ok !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cksum_bad: got %b required 0", cksum_ok);
        end
    endtask
`endif

    initial begin
        $display("[TB] sprite_ram_loader bench start");
        test_reset();
        test_full_load();
        test_gapped();
        test_wrap_random();
        test_abort();
        test_reset_midload();
`ifdef SPRITE_LOADER_CKSUM_EN
        test_cksum();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
